mips_multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle MIPS stub datapath.
- Sequences fetch/decode/execute/memory/writeback over one shared ALU, one shared memory port and the register file.
- Drives `alu_op` and `alu_f_sel` into `alu_control`. Encodings: `alu_op` 001 = add, 010 = sub, 100 = decode from F. `alu_f_sel` picks whether F is funct (0) or opcode (1).
- Counts retired instructions.

---
 rtl/mips_multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Main control FSM for the multi-cycle MIPS stub datapath. Sequences
//   fetch / decode / execute / memory / writeback over one shared ALU, one
//   shared memory port and the register file, and counts retired
//   instructions.
//
// Build option:
//   MIPS_CTRL_BNE_EN - when defined, opcode 000101 (bne) is accepted and
//                      branches on ~zero; when undefined it is illegal.
//
// Ports:
//   clk, rstb          clock, synchronous active-low reset
//   opcode             IR[31:26], valid from DECODE onward
//   zero               ALU zero flag for the current cycle
//   mem_ready          memory access completes in the cycle it is 1
//   alu_op, alu_f_sel  ALU control (001 add, 010 sub, 100 decode F;
//                      F = funct when alu_f_sel = 0, opcode when 1)
//   alu_src_a/b        ALU operand selects
//   pc_source          PC next-value select
//   pc_write, ir_write PC / IR load strobes
//   i_or_d             memory address select (0 PC, 1 ALUOut)
//   mem_read/mem_write memory requests
//   reg_write, reg_dst, mem_to_reg  register file write control
//   illegal_op         one-cycle pulse in DECODE for an unsupported opcode
//   state              current state code (debug)
//   instr_count        retired instruction count, wraps modulo 2^CNT_W

module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       alu_op,
  output logic             alu_f_sel,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic             pc_write,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t cur;

  logic pc_write_s, ir_write_s, mem_read_s, mem_write_s, reg_write_s, illegal_s;

`ifdef MIPS_CTRL_BNE_EN
  // Set in DECODE when the instruction is bne, so BRANCH inverts the test.
  logic bne_q;
`endif

  // Opcodes the controller knows how to sequence.
  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    ok = (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                     6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010});
`ifdef MIPS_CTRL_BNE_EN
    ok = ok | (op == 6'b000101);
`endif
    return ok;
  endfunction

  // State register, branch-kind flag and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      cur         <= S_FETCH;
      instr_count <= '0;
`ifdef MIPS_CTRL_BNE_EN
      bne_q       <= 1'b0;
`endif
    end else begin
      case (cur)
        S_FETCH: if (mem_ready) cur <= S_DECODE;
        S_DECODE: begin
`ifdef MIPS_CTRL_BNE_EN
          bne_q <= (opcode == 6'b000101);
`endif
          case (opcode)
            6'b000000:                         cur <= S_EXEC_R;
            6'b100011, 6'b101011:              cur <= S_MEM_ADDR;
            6'b000100:                         cur <= S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
            6'b000101:                         cur <= S_BRANCH;
`endif
            6'b000010:                         cur <= S_JUMP;
            6'b001000, 6'b001100, 6'b001101,
            6'b001110, 6'b001010:              cur <= S_EXEC_I;
            default:                           cur <= S_FETCH;
          endcase
        end
        S_MEM_ADDR: cur <= (opcode == 6'b101011) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ: if (mem_ready) cur <= S_MEM_WB;
        S_MEM_WRITE: begin
          if (mem_ready) begin
            cur         <= S_FETCH;
            instr_count <= instr_count + CNT_ONE;
          end
        end
        S_EXEC_R: cur <= S_R_WB;
        S_EXEC_I: cur <= S_I_WB;
        S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
          cur         <= S_FETCH;
          instr_count <= instr_count + CNT_ONE;
        end
        default: cur <= S_FETCH;
      endcase
    end
  end

  // Per-state output decode; only the qualified strobes look at inputs.
  always_comb begin
    alu_op      = 3'b001;
    alu_f_sel   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_source   = 2'b00;
    i_or_d      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    illegal_s   = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read_s = 1'b1;
        alu_src_b  = 2'b01;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        illegal_s = ~op_legal(opcode);
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read_s = 1'b1;
        i_or_d     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_s = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_s = 1'b1;
        i_or_d      = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b100;
      end
      S_R_WB: begin
        reg_write_s = 1'b1;
        reg_dst     = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b100;
        alu_f_sel = 1'b1;
      end
      S_I_WB: begin
        reg_write_s = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        pc_source = 2'b01;
`ifdef MIPS_CTRL_BNE_EN
        pc_write_s = bne_q ? ~zero : zero;
`else
        pc_write_s = zero;
`endif
      end
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_write_s = 1'b1;
      end
      default: begin
        alu_op = 3'b001;
      end
    endcase
  end

  // Strobes are held off for the whole reset so an abandoned instruction
  // cannot write anything.
  assign pc_write   = pc_write_s  & rstb;
  assign ir_write   = ir_write_s  & rstb;
  assign mem_read   = mem_read_s  & rstb;
  assign mem_write  = mem_write_s & rstb;
  assign reg_write  = reg_write_s & rstb;
  assign illegal_op = illegal_s   & rstb;
  assign state      = cur;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstb;
  logic [5:0]    opcode;
  logic          zero, mem_ready;
  logic [2:0]    alu_op;
  logic          alu_f_sel, alu_src_a;
  logic [1:0]    alu_src_b, pc_source;
  logic          pc_write, ir_write, i_or_d, mem_read, mem_write;
  logic          reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rstb(rstb), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_f_sel(alu_f_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .pc_write(pc_write),
    .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .state(state),
    .instr_count(instr_count)
  );

  function automatic logic legal(input logic [5:0] op);
    logic ok;
    ok = (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                     6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010});
`ifdef MIPS_CTRL_BNE_EN
    ok = ok | (op == 6'b000101);
`endif
    return ok;
  endfunction

  // Expected output word for one cycle, from the per-state output table.
  function automatic logic [17:0] exp_out(input int code, input logic mr,
                                          input logic z, input logic [5:0] op);
    logic [2:0] aop; logic fs, sa, pw, iw, iod, mrd, mwr, rw, rd, m2r, ill;
    logic [1:0] sb, ps;
    aop = 3'b001; {fs, sa, pw, iw, iod, mrd, mwr, rw, rd, m2r, ill} = 11'b0;
    sb = 2'b00; ps = 2'b00;
    case (code)
      0:  begin mrd = 1'b1; sb = 2'b01; iw = mr; pw = mr; end
      1:  begin sb = 2'b11; ill = ~legal(op); end
      2:  begin sa = 1'b1; sb = 2'b10; end
      3:  begin mrd = 1'b1; iod = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mwr = 1'b1; iod = 1'b1; end
      6:  begin sa = 1'b1; aop = 3'b100; end
      7:  begin rw = 1'b1; rd = 1'b1; end
      8:  begin sa = 1'b1; sb = 2'b10; aop = 3'b100; fs = 1'b1; end
      9:  begin rw = 1'b1; end
      10: begin sa = 1'b1; aop = 3'b010; ps = 2'b01;
                pw = (op == 6'b000101) ? ~z : z; end
      11: begin ps = 2'b10; pw = 1'b1; end
      default: begin aop = 3'b001; end
    endcase
    return {aop, fs, sa, sb, ps, pw, iw, iod, mrd, mwr, rw, rd, m2r, ill};
  endfunction

  // Runs one instruction from FETCH. fs/ms: stall cycles in FETCH and in the
  // memory state; zmode: 0/1 forces zero, 2 randomizes it per cycle.
  task automatic run_instr(input logic [5:0] op, input int fs, input int ms,
                           input int zmode);
    int codes[$];
    int modes[$];   // mem_ready per cycle: 0, 1, or 2 = don't care (random)
    logic mr, z;
    logic [17:0] obs, exp;
    repeat (fs) begin codes.push_back(0); modes.push_back(0); end
    codes.push_back(0); modes.push_back(1);
    codes.push_back(1); modes.push_back(2);
    if (op == 6'b000000) begin
      codes.push_back(6); modes.push_back(2); codes.push_back(7); modes.push_back(2);
    end else if (op == 6'b100011) begin
      codes.push_back(2); modes.push_back(2);
      repeat (ms) begin codes.push_back(3); modes.push_back(0); end
      codes.push_back(3); modes.push_back(1); codes.push_back(4); modes.push_back(2);
    end else if (op == 6'b101011) begin
      codes.push_back(2); modes.push_back(2);
      repeat (ms) begin codes.push_back(5); modes.push_back(0); end
      codes.push_back(5); modes.push_back(1);
    end else if (op == 6'b000100 || (op == 6'b000101 && legal(op))) begin
      codes.push_back(10); modes.push_back(2);
    end else if (op == 6'b000010) begin
      codes.push_back(11); modes.push_back(2);
    end else if (legal(op)) begin
      codes.push_back(8); modes.push_back(2); codes.push_back(9); modes.push_back(2);
    end
    for (int i = 0; i < codes.size(); i++) begin
      @(negedge clk);
      mr = (modes[i] == 2) ? 1'($urandom) : modes[i][0];
      z  = (zmode == 2) ? 1'($urandom) : zmode[0];
      mem_ready = mr;
      zero      = z;
      opcode    = (codes[i] == 0) ? 6'($urandom) : op;
      #1;
      total++;
      if (state !== 4'(codes[i])) begin
        bad++;
        $display("FAIL state op=%b step=%0d got=%0d want=%0d", op, i, state, codes[i]);
      end
      obs = {alu_op, alu_f_sel, alu_src_a, alu_src_b, pc_source, pc_write, ir_write,
             i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, illegal_op};
      exp = exp_out(codes[i], mr, z, op);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL outputs op=%b step=%0d state=%0d got=%b want=%b", op, i, codes[i], obs, exp);
      end
      @(posedge clk); #1;
    end
    if (legal(op)) exp_cnt = (exp_cnt + 1) % (1 << CW);
    total++;
    if (state !== 4'd0) begin
      bad++;
      $display("FAIL return_to_fetch op=%b got=%0d want=0", op, state);
    end
    total++;
    if (instr_count !== CW'(exp_cnt)) begin
      bad++;
      $display("FAIL instr_count op=%b got=%0d want=%0d", op, instr_count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = 6'b000000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (state !== 4'd0 || instr_count !== '0) begin
      bad++;
      $display("FAIL reset_state got state=%0d count=%0d want 0/0", state, instr_count);
    end
    total++;
    if ({pc_write, ir_write, mem_read, mem_write, reg_write, illegal_op} !== 6'b0) begin
      bad++;
      $display("FAIL reset_strobes got=%b want=000000",
               {pc_write, ir_write, mem_read, mem_write, reg_write, illegal_op});
    end
    rstb = 1'b1;
    @(posedge clk); #1;
    total++;
    if (state !== 4'd1) begin
      bad++;
      $display("FAIL reset_release got=%0d want=1", state);
    end
    @(negedge clk); rstb = 1'b0;
    @(posedge clk); #1; rstb = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_rtype();    run_instr(6'b000000, 0, 0, 2); endtask
  task automatic test_lw_stall(); run_instr(6'b100011, 0, 3, 2); endtask
  task automatic test_sw_stall(); run_instr(6'b101011, 2, 2, 2); endtask
  task automatic test_beq();
    run_instr(6'b000100, 0, 0, 1);
    run_instr(6'b000100, 0, 0, 0);
  endtask
  task automatic test_ori();      run_instr(6'b001101, 1, 0, 2); endtask
  task automatic test_jump();     run_instr(6'b000010, 0, 0, 2); endtask
  task automatic test_illegal();
    run_instr(6'b111111, 0, 0, 2);
    run_instr(6'b000101, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = 1'b1; opcode = 6'b000000;
      @(posedge clk);
    end
    @(negedge clk); rstb = 1'b0; #1;
    total++;
    if (state !== 4'd7 || reg_write !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_wb got state=%0d reg_write=%b want 7/0", state, reg_write);
    end
    @(posedge clk); #1;
    exp_cnt = 0;
    total++;
    if (state !== 4'd0 || instr_count !== '0) begin
      bad++;
      $display("FAIL reset_mid_after got state=%0d count=%0d want 0/0", state, instr_count);
    end
    rstb = 1'b1;
  endtask

  task automatic test_random();
    logic [5:0] pool [11];
    logic [5:0] op;
    pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000,
             6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b000101};
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 5) == 0) ? 6'($urandom) : pool[$urandom_range(0, 10)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 2);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw_stall();
    test_beq();
    test_ori();
    test_jump();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
